// File: rtl/diff_fm_pingpong_buf_if.sv
// Load/compute bus of the ping-pong fm/guard buffer bank.
// The load engine and the compute array drive the master side; the buffer is the slave.
interface diff_fm_pingpong_buf_if #(
    parameter int NUM_COL = 4,
    parameter int DATA_W  = 72,
    parameter int AW      = 9
);
    logic [NUM_COL*AW-1:0]         load_wr_addr;
    logic [NUM_COL*DATA_W-1:0]     load_din;
    logic [NUM_COL-1:0]            load_wr_en;
    logic [NUM_COL*(DATA_W/8)-1:0] load_wr_be;
    logic                          load_ready;
    logic                          load_done;
    logic [NUM_COL*AW-1:0]         rd_addr;
    logic [NUM_COL-1:0]            rd_en;
    logic [NUM_COL*DATA_W-1:0]     rd_dout;
    logic [NUM_COL-1:0]            rd_valid;
    logic                          rd_bank_valid;
    logic                          rd_release;
    logic [1:0]                    full_cnt;
    logic                          err_overflow;
    logic                          err_underflow;

    modport master (
        output load_wr_addr, load_din, load_wr_en, load_wr_be, load_done,
        output rd_addr, rd_en, rd_release,
        input  load_ready, rd_dout, rd_valid, rd_bank_valid, full_cnt,
        input  err_overflow, err_underflow
    );

    modport slave (
        input  load_wr_addr, load_din, load_wr_en, load_wr_be, load_done,
        input  rd_addr, rd_en, rd_release,
        output load_ready, rd_dout, rd_valid, rd_bank_valid, full_cnt,
        output err_overflow, err_underflow
    );
endinterface

// File: rtl/diff_fm_pingpong_buf.sv
// Two-bank ping-pong buffer, one memory per PE column: the load side fills one bank
// while the PE array reads the other; banks swap through load_done / rd_release.
module diff_fm_pingpong_buf #(
    parameter int NUM_COL = 4,
    parameter int DATA_W  = 72,
    parameter int DEPTH   = 512,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    diff_fm_pingpong_buf_if.slave    bus
);
    localparam int BE_W = DATA_W / 8;

    logic                      wr_sel_q, wr_sel_d;
    logic                      rd_sel_q, rd_sel_d;
    logic [1:0]                bank_full_q, bank_full_d;
    logic                      err_ovf_q, err_ovf_d;
    logic                      err_unf_q, err_unf_d;
    logic [NUM_COL-1:0]        rd_valid_q, rd_valid_d;
    logic [NUM_COL*DATA_W-1:0] rd_dout_q;
    logic                      load_ready;
    logic                      rd_bank_valid;
    logic                      commit;
    logic                      release_ok;

    // Bank select is the address MSB: {bank, word}.
    logic [DATA_W-1:0] mem_q [NUM_COL][2*DEPTH];

    assign load_ready    = ~bank_full_q[wr_sel_q];
    assign rd_bank_valid = bank_full_q[rd_sel_q];

    assign bus.load_ready    = load_ready;
    assign bus.rd_bank_valid = rd_bank_valid;
    assign bus.full_cnt      = {1'b0, bank_full_q[0]} + {1'b0, bank_full_q[1]};
    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_unf_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_dout       = rd_dout_q;

    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    always_comb begin
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        bank_full_d = bank_full_q;
        commit      = bus.load_done & load_ready;
        release_ok  = bus.rd_release & rd_bank_valid;
        rd_valid_d  = bus.rd_en & {NUM_COL{rd_bank_valid}};
        err_ovf_d   = err_ovf_q | (~load_ready & (bus.load_done | (|bus.load_wr_en)));
        err_unf_d   = err_unf_q | (~rd_bank_valid & (bus.rd_release | (|bus.rd_en)));
        // Commit needs an empty write bank, release a full read bank, so they never collide.
        if (commit) begin
            bank_full_d[wr_sel_q] = 1'b1;
            wr_sel_d              = ~wr_sel_q;
        end
        if (release_ok) begin
            bank_full_d[rd_sel_q] = 1'b0;
            rd_sel_d              = ~rd_sel_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            bank_full_q <= 2'b00;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
            rd_valid_q  <= '0;
            rd_dout_q   <= '0;
        end else begin
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            bank_full_q <= bank_full_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
            rd_valid_q  <= rd_valid_d;
            for (int c = 0; c < NUM_COL; c++) begin
                if (rd_valid_d[c]) begin
                    rd_dout_q[c*DATA_W +: DATA_W] <= mem_q[c][{rd_sel_q, bus.rd_addr[c*AW +: AW]}];
                end
            end
        end
    end

    // NOTE: the memory array is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_COL; c++) begin
            if (bus.load_wr_en[c] && load_ready) begin
                for (int k = 0; k < BE_W; k++) begin
                    if (bus.load_wr_be[c*BE_W + k]) begin
                        mem_q[c][{wr_sel_q, bus.load_wr_addr[c*AW +: AW]}][k*8 +: 8]
                            <= bus.load_din[c*DATA_W + k*8 +: 8];
                    end
                end
            end
        end
    end
endmodule
